axi_rd_target: RTL and testbench

Parametrised AXI read target that sits on the read half of the AXI bus (AR and R channels) and serves bursts from a synchronous single-port memory read port. Supports FIXED, INCR and, optionally, WRAP bursts. Queues up to AQ_DEPTH outstanding AR requests, generates per-beat word addresses, and returns data in order through a 2-entry R buffer at up to one beat per cycle. Illegal bursts and out-of-range beats are answered with full-length error responses.

---
 rtl/axi_pkg.sv | 45 ++++
 rtl/axi_burst_addr_gen.sv | 45 ++++
 rtl/axi_rd_target.sv | 187 ++++++++++++++++++
 tb/tb_axi_rd_target.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: shared constants and types for the AXI read target.
//   - burst type and response encodings
//   - aq_meta_t: per-request metadata held in the AR queue
//   - beat_t: one issued beat travelling through the memory read stage
//   - enq_resp(): legality check of a request, decided when it is queued
// Optional feature macro: AXI_WRAP_EN (WRAP bursts legal only when defined).
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef struct packed {
        logic [7:0] len;
        logic [1:0] burst;
        logic [1:0] resp;
    } aq_meta_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] resp;
        logic       last;
    } beat_t;

    function automatic logic [1:0] enq_resp(input logic [1:0] burst, input logic [7:0] len);
        logic [1:0] r;
        case (burst)
            BURST_FIXED: r = (len > 8'd15) ? RESP_SLVERR : RESP_OKAY;
            BURST_INCR:  r = RESP_OKAY;
`ifdef AXI_WRAP_EN
            BURST_WRAP:  r = (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
                             ? RESP_OKAY : RESP_SLVERR;
`else
            BURST_WRAP:  r = RESP_SLVERR;
`endif
            default:     r = RESP_SLVERR;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: combinational next word address of a burst.
// Ports:
//   addr      in  WA_W  current beat word address
//   burst     in  2     FIXED / INCR / WRAP
//   len       in  8     burst length minus one (wrap mask for WRAP)
//   next_addr out WA_W  word address of the following beat
// WRAP logic is compiled only when AXI_WRAP_EN is defined.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int WA_W = 28
) (
    input  logic [WA_W-1:0] addr,
    input  logic [1:0]      burst,
    input  logic [7:0]      len,
    output logic [WA_W-1:0] next_addr
);

    logic [WA_W-1:0] incr_addr;
    assign incr_addr = addr + {{(WA_W-1){1'b0}}, 1'b1};

`ifdef AXI_WRAP_EN
    // Legal WRAP lengths are 2^n-1, so len itself is the in-window mask.
    logic [WA_W-1:0] wrap_mask;
    logic [WA_W-1:0] wrap_addr;
    assign wrap_mask = WA_W'(len);
    assign wrap_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
`else
    logic unused_len;
    assign unused_len = ^len;
`endif

    always_comb begin
        next_addr = addr;
        if (burst == BURST_INCR) begin
            next_addr = incr_addr;
        end
`ifdef AXI_WRAP_EN
        else if (burst == BURST_WRAP) begin
            next_addr = wrap_addr;
        end
`endif
    end

endmodule

// File: rtl/axi_rd_target.sv
// axi_rd_target: AXI read target (AR + R channels) serving bursts from a
// synchronous memory read port (data valid the cycle after mem_re).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   arvalid/arready, araddr, arburst, arlen   AR channel
//   rvalid/rready, rdata, rresp, rlast        R channel
//   mem_re, mem_addr, mem_rdata               memory read port
// Optional feature macro: AXI_WRAP_EN enables WRAP bursts; without it every
// WRAP request returns len+1 SLVERR beats and never touches memory.
module axi_rd_target
    import axi_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 128,
    parameter int AQ_DEPTH = 4,
    parameter int MEM_AW   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [1:0]        arburst,
    input  logic [7:0]        arlen,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              mem_re,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int BB_LG = $clog2(DATA_W / 8);
    localparam int WA_W  = ADDR_W - BB_LG;
    localparam int AQ_PW = $clog2(AQ_DEPTH);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    // ---------------- AR queue ----------------
    logic [WA_W-1:0]  aq_addr_mem [AQ_DEPTH];
    aq_meta_t         aq_meta_mem [AQ_DEPTH];
    logic [AQ_PW-1:0] aq_wr_ptr_reg, aq_rd_ptr_reg;
    logic [AQ_PW:0]   aq_count_reg, aq_count_next;
    logic             arready_reg;
    logic             aq_push, aq_pop;
    aq_meta_t         aq_head;
    state_t           state_reg;

    logic unused_araddr;
    assign unused_araddr = ^araddr[BB_LG-1:0];

    assign arready = arready_reg;
    assign aq_push = arvalid & arready_reg;
    assign aq_pop  = (state_reg == S_IDLE) && (aq_count_reg != '0);
    assign aq_head = aq_meta_mem[aq_rd_ptr_reg];
    assign aq_count_next = aq_count_reg + {{AQ_PW{1'b0}}, aq_push} - {{AQ_PW{1'b0}}, aq_pop};

    always_ff @(posedge clk) begin
        if (aq_push) begin
            aq_addr_mem[aq_wr_ptr_reg] <= araddr[ADDR_W-1:BB_LG];
            aq_meta_mem[aq_wr_ptr_reg] <= '{len: arlen, burst: arburst, resp: enq_resp(arburst, arlen)};
        end
    end

    // arready is registered from the next occupancy so it is low in reset
    // and reflects a pop one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aq_wr_ptr_reg <= '0;
            aq_rd_ptr_reg <= '0;
            aq_count_reg  <= '0;
            arready_reg   <= 1'b0;
        end else begin
            if (aq_push) aq_wr_ptr_reg <= aq_wr_ptr_reg + 1'b1;
            if (aq_pop)  aq_rd_ptr_reg <= aq_rd_ptr_reg + 1'b1;
            aq_count_reg <= aq_count_next;
            arready_reg  <= (aq_count_next != (AQ_PW+1)'(AQ_DEPTH));
        end
    end

    // ---------------- burst FSM and beat issue ----------------
    logic [WA_W-1:0] b_addr_reg, b_next_addr;
    logic [7:0]      b_left_reg, b_len_reg;
    logic [1:0]      b_burst_reg, b_err_reg;
    beat_t           pipe_reg;
    logic [1:0]      rb_count_reg;
    logic            rb_pop, credit_ok, issue, out_of_range;
    logic [2:0]      occ;
    logic [1:0]      beat_resp;

    axi_burst_addr_gen #(.WA_W(WA_W)) u_addr_gen (
        .addr      (b_addr_reg),
        .burst     (b_burst_reg),
        .len       (b_len_reg),
        .next_addr (b_next_addr)
    );

    // A beat may issue only if it will find a free R buffer slot when its
    // data returns, counting the beat already in the memory stage.
    assign occ          = {1'b0, rb_count_reg} + {2'b0, pipe_reg.valid} - {2'b0, rb_pop};
    assign credit_ok    = (occ < 3'd2);
    assign issue        = (state_reg == S_BURST) && credit_ok;
    assign out_of_range = |b_addr_reg[WA_W-1:MEM_AW];
    assign beat_resp    = (b_err_reg != RESP_OKAY) ? b_err_reg :
                          (out_of_range ? RESP_DECERR : RESP_OKAY);
    assign mem_re       = issue && (beat_resp == RESP_OKAY);
    assign mem_addr     = b_addr_reg[MEM_AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            b_addr_reg  <= '0;
            b_left_reg  <= '0;
            b_len_reg   <= '0;
            b_burst_reg <= '0;
            b_err_reg   <= '0;
            pipe_reg    <= '0;
        end else begin
            pipe_reg <= '{valid: issue, resp: beat_resp, last: (b_left_reg == 8'd0)};
            case (state_reg)
                S_IDLE: begin
                    if (aq_pop) begin
                        b_addr_reg  <= aq_addr_mem[aq_rd_ptr_reg];
                        b_left_reg  <= aq_head.len;
                        b_len_reg   <= aq_head.len;
                        b_burst_reg <= aq_head.burst;
                        b_err_reg   <= aq_head.resp;
                        state_reg   <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (issue) begin
                        b_addr_reg <= b_next_addr;
                        b_left_reg <= b_left_reg - 8'd1;
                        if (b_left_reg == 8'd0) state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // ---------------- 2-entry R buffer ----------------
    logic [DATA_W-1:0] rb_data_mem [2];
    logic [1:0]        rb_resp_mem [2];
    logic              rb_last_mem [2];
    logic              rb_wr_ptr_reg, rb_rd_ptr_reg;
    logic [DATA_W-1:0] rb_wdata;

    assign rvalid   = (rb_count_reg != 2'd0);
    assign rb_pop   = rvalid & rready;
    assign rb_wdata = (pipe_reg.resp == RESP_OKAY) ? mem_rdata : '0;
    assign rdata    = rb_data_mem[rb_rd_ptr_reg];
    assign rresp    = rb_resp_mem[rb_rd_ptr_reg];
    assign rlast    = rb_last_mem[rb_rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rb_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rb_data_mem[gi] <= '0;
                    rb_resp_mem[gi] <= '0;
                    rb_last_mem[gi] <= 1'b0;
                end else if (pipe_reg.valid && (rb_wr_ptr_reg == 1'(gi))) begin
                    rb_data_mem[gi] <= rb_wdata;
                    rb_resp_mem[gi] <= pipe_reg.resp;
                    rb_last_mem[gi] <= pipe_reg.last;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_wr_ptr_reg <= 1'b0;
            rb_rd_ptr_reg <= 1'b0;
            rb_count_reg  <= 2'd0;
        end else begin
            if (pipe_reg.valid) rb_wr_ptr_reg <= ~rb_wr_ptr_reg;
            if (rb_pop)         rb_rd_ptr_reg <= ~rb_rd_ptr_reg;
            rb_count_reg <= rb_count_reg + {1'b0, pipe_reg.valid} - {1'b0, rb_pop};
        end
    end

endmodule

// File: tb/tb_axi_rd_target.sv
module tb_axi_rd_target;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int MEM_AW = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [ADDR_W-1:0] araddr = '0;
    logic [1:0]        arburst = '0;
    logic [7:0]        arlen = '0;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              mem_re;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;

    axi_rd_target #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AQ_DEPTH(4), .MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arburst(arburst), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [DATA_W-1:0] mem_word(input logic [MEM_AW-1:0] a);
        logic [31:0] w;
        w = {22'd0, a};
        return {32'hDA7A_0000 | w, ~w, 32'h0123_4567 ^ w, w};
    endfunction

    // Memory model: synchronous read, data one cycle after mem_re.
    always @(posedge clk) if (mem_re) mem_rdata <= mem_word(mem_addr);

    logic [MEM_AW-1:0] mem_log[$];
    always @(negedge clk) if (mem_re) mem_log.push_back(mem_addr);

    task automatic chk_i(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_d(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_ar(input logic [1:0] b, input logic [31:0] a, input logic [7:0] l,
                           output int hs_cyc);
        bit done;
        done = 0;
        hs_cyc = -1;
        arvalid = 1'b1; arburst = b; araddr = a; arlen = l;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (arready) begin
                hs_cyc = cyc;
                done = 1;
            end
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        chk_i("ar_accept", int'(done), 1);
    endtask

    typedef struct {
        string            name;
        logic [1:0]       burst;
        logic [31:0]      addr;
        logic [7:0]       len;
        int               nbeats;
        logic [1:0]       resp0;
        logic [1:0]       resp1;
        int               nmem;
        logic [MEM_AW-1:0] ma [4];
    } vec_t;

    function automatic vec_t mk(input string n, input logic [1:0] b, input logic [31:0] a,
                                input logic [7:0] l, input int nb, input logic [1:0] r0,
                                input logic [1:0] r1, input int nm,
                                input logic [MEM_AW-1:0] m0, input logic [MEM_AW-1:0] m1,
                                input logic [MEM_AW-1:0] m2, input logic [MEM_AW-1:0] m3);
        vec_t v;
        v.name = n; v.burst = b; v.addr = a; v.len = l; v.nbeats = nb;
        v.resp0 = r0; v.resp1 = r1; v.nmem = nm;
        v.ma[0] = m0; v.ma[1] = m1; v.ma[2] = m2; v.ma[3] = m3;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int hs_cyc, first_cyc, last_cyc, got, extra;
        logic [1:0] er;
        logic [DATA_W-1:0] exp_d;
        mem_log.delete();
        rready = 1'b1;
        send_ar(v.burst, v.addr, v.len, hs_cyc);
        got = 0; first_cyc = -1; last_cyc = -1;
        for (int t = 0; t < 200 && got < v.nbeats; t++) begin
            @(negedge clk);
            if (rvalid) begin
                er = (got == 0) ? v.resp0 : v.resp1;
                exp_d = (er == 2'd0) ? mem_word(v.ma[got & 3]) : '0;
                chk_i({v.name, "_rresp"}, int'(rresp), int'(er));
                chk_d({v.name, "_rdata"}, rdata, exp_d);
                chk_i({v.name, "_rlast"}, int'(rlast), int'(got == v.nbeats - 1));
                if (got == 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
        end
        chk_i({v.name, "_beats"}, got, v.nbeats);
        chk_i({v.name, "_latency"}, first_cyc - hs_cyc, 4);
        chk_i({v.name, "_span"}, last_cyc - first_cyc, v.nbeats - 1);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (rvalid) extra++;
        end
        chk_i({v.name, "_extra"}, extra, 0);
        chk_i({v.name, "_nmem"}, mem_log.size(), v.nmem);
        for (int i = 0; i < v.nmem && i < mem_log.size(); i++)
            chk_i({v.name, "_mem_addr"}, int'(mem_log[i]), int'(v.ma[i]));
        $display("vec %s: burst=%0d addr=0x%0h len=%0d beats=%0d mem_reads=%0d",
                 v.name, v.burst, v.addr, v.len, got, mem_log.size());
        @(posedge clk); #1;
    endtask

    vec_t vecs [8];
    int hs, got, extra, sz;
    bit acc;

    initial begin
        vecs[0] = mk("incr4",   2'd1, 32'h100,  8'd3,  4, 2'd0, 2'd0, 4, 10'h10, 10'h11, 10'h12, 10'h13);
`ifdef AXI_WRAP_EN
        vecs[1] = mk("wrap4",   2'd2, 32'h130,  8'd3,  4, 2'd0, 2'd0, 4, 10'h13, 10'h10, 10'h11, 10'h12);
`else
        vecs[1] = mk("wrap4",   2'd2, 32'h130,  8'd3,  4, 2'd2, 2'd2, 0, 10'h0, 10'h0, 10'h0, 10'h0);
`endif
        vecs[2] = mk("fixed17", 2'd0, 32'h40,   8'd16, 17, 2'd2, 2'd2, 0, 10'h0, 10'h0, 10'h0, 10'h0);
        vecs[3] = mk("rsvd1",   2'd3, 32'h80,   8'd0,  1, 2'd2, 2'd2, 0, 10'h0, 10'h0, 10'h0, 10'h0);
        vecs[4] = mk("decerr",  2'd1, 32'h3FF0, 8'd1,  2, 2'd0, 2'd3, 1, 10'h3FF, 10'h0, 10'h0, 10'h0);
        vecs[5] = mk("fixed3",  2'd0, 32'h5C,   8'd2,  3, 2'd0, 2'd0, 3, 10'h5, 10'h5, 10'h5, 10'h5);
        vecs[6] = mk("wrapbad", 2'd2, 32'h200,  8'd2,  3, 2'd2, 2'd2, 0, 10'h0, 10'h0, 10'h0, 10'h0);
        vecs[7] = mk("incr1",   2'd1, 32'h2F,   8'd0,  1, 2'd0, 2'd0, 1, 10'h2, 10'h0, 10'h0, 10'h0);

        // ---- reset state ----
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_i("rst_arready", int'(arready), 0);
        chk_i("rst_rvalid", int'(rvalid), 0);
        chk_d("rst_rdata", rdata, '0);
        chk_i("rst_rresp", int'(rresp), 0);
        chk_i("rst_rlast", int'(rlast), 0);
        chk_i("rst_mem_re", int'(mem_re), 0);
        chk_i("rst_mem_addr", int'(mem_addr), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_i("arready_after_reset", int'(arready), 1);
        $display("reset: arready=%0d rvalid=%0d", arready, rvalid);
        @(posedge clk); #1;

        // ---- table-driven bursts ----
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // ---- queue fill with R stalled ----
        rready = 1'b0;
        mem_log.delete();
        for (int i = 0; i < 7; i++) send_ar(2'd1, 32'(i * 16), 8'd0, hs);
        arvalid = 1'b1; araddr = 32'h70; arlen = 8'd0; arburst = 2'd1;
        repeat (5) @(negedge clk);
        chk_i("qfull_arready", int'(arready), 0);
        chk_i("stall_rvalid", int'(rvalid), 1);
        chk_d("stall_rdata", rdata, mem_word(10'd0));
        chk_i("stall_rlast", int'(rlast), 1);
        $display("queue full: arready=%0d rvalid=%0d", arready, rvalid);
        @(posedge clk); #1;
        acc = 0; got = 0;
        fork
            begin
                for (int t = 0; t < 50 && !acc; t++) begin
                    @(negedge clk);
                    if (arready) acc = 1;
                    @(posedge clk); #1;
                end
                arvalid = 1'b0;
            end
            begin
                rready = 1'b1;
                for (int t = 0; t < 100 && got < 8; t++) begin
                    @(negedge clk);
                    if (rvalid) begin
                        chk_d("qfill_rdata", rdata, mem_word(10'(got)));
                        chk_i("qfill_rresp", int'(rresp), 0);
                        chk_i("qfill_rlast", int'(rlast), 1);
                        got++;
                    end
                end
            end
        join
        chk_i("qfill_ar8_accept", int'(acc), 1);
        chk_i("qfill_beats", got, 8);
        chk_i("qfill_nmem", mem_log.size(), 8);
        $display("queue drain: beats=%0d mem_reads=%0d", got, mem_log.size());
        @(posedge clk); #1;

        // ---- reset in the middle of an INCR burst ----
        mem_log.delete();
        rready = 1'b1;
        send_ar(2'd1, 32'h0, 8'd7, hs);
        got = 0;
        for (int t = 0; t < 50 && got < 3; t++) begin
            @(negedge clk);
            if (rvalid) got++;
        end
        chk_i("midrst_pre_beats", got, 3);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        sz = mem_log.size();
        chk_i("midrst_arready", int'(arready), 0);
        chk_i("midrst_rvalid", int'(rvalid), 0);
        chk_d("midrst_rdata", rdata, '0);
        chk_i("midrst_rresp", int'(rresp), 0);
        chk_i("midrst_rlast", int'(rlast), 0);
        chk_i("midrst_mem_re", int'(mem_re), 0);
        chk_i("midrst_mem_addr", int'(mem_addr), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (rvalid) extra++;
        end
        chk_i("midrst_no_beats", extra, 0);
        chk_i("midrst_no_mem", mem_log.size(), sz);
        $display("mid-burst reset: beats_after=%0d", extra);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
